// File: rtl/ucq_push_arbiter.sv
// Round-robin arbiter sharing the uc_queue push port among NUM_REQ producers,
// using a credit counter to avoid overflow. Optional literal dedup: UCQ_DEDUP_EN.
`ifndef UC_LENGTH
`define UC_LENGTH 64
`endif

module ucq_push_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int LIT_W       = $clog2(`UC_LENGTH) + 1,
  parameter int QUEUE_DEPTH = 4,
  localparam int CW = $clog2(QUEUE_DEPTH) + 1,
  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*LIT_W-1:0] req_lit,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic                     ucq_full,
  input  logic                     ucq_empty,
  input  logic                     ucq_pop,
  output logic                     ucq_push,
  output logic [LIT_W-1:0]         ucq_data,
  output logic [CW-1:0]            credits
);

  logic [PW-1:0]    ptr_q, ptr_d;
  logic [CW-1:0]    cred_q, cred_d;
  logic             push_q, push_d;
  logic [LIT_W-1:0] data_q, data_d;

  logic             gnt_any;
  logic [PW-1:0]    gnt_idx;
  logic [LIT_W-1:0] gnt_lit;
  logic             do_push;
  logic             inc;
  int               idx;

  // Cyclic first-valid search starting at the round-robin pointer.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    idx     = 0;
    if (rst && cred_q != '0) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        idx = (int'(ptr_q) + k) % NUM_REQ;
        if (!gnt_any && req_valid[PW'(idx)]) begin
          gnt_any = 1'b1;
          gnt_idx = PW'(idx);
        end
      end
    end
  end

  assign req_ready = gnt_any ? (NUM_REQ'(1) << gnt_idx) : '0;
  assign gnt_lit   = req_lit[gnt_idx*LIT_W +: LIT_W];
  assign inc       = ucq_pop & ~ucq_empty;

`ifdef UCQ_DEDUP_EN
  logic [LIT_W-1:0] last_lit_q, last_lit_d;
  logic             last_vld_q, last_vld_d;

  // A repeat of the last pushed literal is acked but never enters the queue.
  assign do_push = gnt_any && !(last_vld_q && gnt_lit == last_lit_q);

  always_comb begin
    last_lit_d = last_lit_q;
    last_vld_d = last_vld_q;
    if (do_push) begin
      last_lit_d = gnt_lit;
      last_vld_d = 1'b1;
    end else if (ucq_empty && !push_q) begin
      last_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      last_lit_q <= '0;
      last_vld_q <= 1'b0;
    end else begin
      last_lit_q <= last_lit_d;
      last_vld_q <= last_vld_d;
    end
  end
`else
  assign do_push = gnt_any;
`endif

  always_comb begin
    ptr_d  = ptr_q;
    cred_d = cred_q;
    push_d = do_push;
    data_d = data_q;
    if (gnt_any)
      ptr_d = (gnt_idx == PW'(NUM_REQ - 1)) ? '0 : gnt_idx + PW'(1);
    if (do_push)
      data_d = gnt_lit;
    if (do_push && !inc)
      cred_d = cred_q - CW'(1);
    else if (!do_push && inc)
      cred_d = cred_q + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      ptr_q  <= '0;
      cred_q <= CW'(QUEUE_DEPTH);
      push_q <= 1'b0;
      data_q <= '0;
    end else begin
      ptr_q  <= ptr_d;
      cred_q <= cred_d;
      push_q <= push_d;
      data_q <= data_d;
    end
  end

  assign ucq_push = push_q;
  assign ucq_data = data_q;
  assign credits  = cred_q;

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (rst) begin
      assert (!(ucq_push && ucq_full)) else $error("push into full uc_queue");
      assert (cred_q <= CW'(QUEUE_DEPTH)) else $error("credits above queue depth");
      assert (!(do_push && !inc && cred_q == '0)) else $error("credit underflow");
      assert (!(inc && !do_push && cred_q == CW'(QUEUE_DEPTH))) else $error("credit overflow");
    end
  end
`endif

endmodule
